// File: rtl/register_file_pkg.sv
// Shared defaults and types for the multi-port integer register file.
package register_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

    // x0 is hard-wired: never written, never busy.
    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/register_scoreboard.sv
// Per-register busy scoreboard: issue reservations set, writebacks and flush clear.
module register_scoreboard
    import register_file_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM_REGS   = 2**ADDR_WIDTH
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic [ADDR_WIDTH-1:0] i_ClrAddr0,
    input  logic                  i_ClrValid0,
    input  logic [ADDR_WIDTH-1:0] i_ClrAddr1,
    input  logic                  i_ClrValid1,
    input  logic [ADDR_WIDTH-1:0] i_IssueAddr,
    input  logic                  i_IssueValid,
    input  logic                  i_Flush,
    output logic [NUM_REGS-1:0]   o_Busy,
    output logic                  o_IssueReady
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                issue_is_zero;

    assign issue_is_zero = (i_IssueAddr == ADDR_WIDTH'(ZERO_REG));
    assign o_IssueReady  = i_Reset & ~i_Flush & (issue_is_zero | ~busy_q[i_IssueAddr]);
    assign o_Busy        = busy_q;

    // Next busy vector: flush or writeback clears first, then an accepted
    // reservation sets, so a same-cycle issue wins over a writeback clear.
    always_comb begin
        busy_d = busy_q;
        if (i_Flush) begin
            busy_d = '0;
        end else begin
            if (i_ClrValid0) busy_d[i_ClrAddr0] = 1'b0;
            if (i_ClrValid1) busy_d[i_ClrAddr1] = 1'b0;
        end
        if (i_IssueValid && o_IssueReady && !issue_is_zero) begin
            busy_d[i_IssueAddr] = 1'b1;
        end
    end

    // Busy state register, cleared asynchronously by reset.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port RV32 register file: two write ports, RD_PORTS read ports,
// optional write-to-read bypass and a busy scoreboard for issue stalls.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int RD_PORTS   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                                i_Clock,
    input  logic                                i_Reset,
    input  logic [ADDR_WIDTH-1:0]               i_WrAddr0,
    input  logic [DATA_WIDTH-1:0]               i_WrData0,
    input  logic                                i_WrEnable0,
    input  logic [ADDR_WIDTH-1:0]               i_WrAddr1,
    input  logic [DATA_WIDTH-1:0]               i_WrData1,
    input  logic                                i_WrEnable1,
    input  logic [RD_PORTS-1:0][ADDR_WIDTH-1:0] i_RdAddr,
    output logic [RD_PORTS-1:0][DATA_WIDTH-1:0] o_RdData,
    output logic [RD_PORTS-1:0]                 o_RdBusy,
    input  logic [ADDR_WIDTH-1:0]               i_IssueAddr,
    input  logic                                i_IssueValid,
    output logic                                o_IssueReady,
    input  logic                                i_Flush
);

    localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic                  wr_ok0;
    logic                  wr_ok1;

    assign wr_ok0 = i_WrEnable0 & (i_WrAddr0 != ADDR_WIDTH'(ZERO_REG));
    assign wr_ok1 = i_WrEnable1 & (i_WrAddr1 != ADDR_WIDTH'(ZERO_REG));

    // Storage update; port 0 is assigned last so it wins an address collision.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wr_ok1) regs_q[i_WrAddr1] <= i_WrData1;
            if (wr_ok0) regs_q[i_WrAddr0] <= i_WrData0;
        end
    end

    register_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_scoreboard (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_ClrAddr0   (i_WrAddr0),
        .i_ClrValid0  (wr_ok0),
        .i_ClrAddr1   (i_WrAddr1),
        .i_ClrValid1  (wr_ok1),
        .i_IssueAddr  (i_IssueAddr),
        .i_IssueValid (i_IssueValid),
        .i_Flush      (i_Flush),
        .o_Busy       (busy),
        .o_IssueReady (o_IssueReady)
    );

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [DATA_WIDTH-1:0] rd_data;
        logic                  rd_busy;
        logic [ADDR_WIDTH-1:0] ra;

        assign ra = i_RdAddr[p];

        // Read mux: x0 and reset force zero; bypass prefers write port 0.
        always_comb begin
            rd_data = '0;
            rd_busy = 1'b0;
            if (i_Reset && (ra != ADDR_WIDTH'(ZERO_REG))) begin
                if ((BYPASS != 0) && wr_ok0 && (i_WrAddr0 == ra)) begin
                    rd_data = i_WrData0;
                end else if ((BYPASS != 0) && wr_ok1 && (i_WrAddr1 == ra)) begin
                    rd_data = i_WrData1;
                end else begin
                    rd_data = regs_q[ra];
                    rd_busy = busy[ra];
                end
            end
        end

        assign o_RdData[p] = rd_data;
        assign o_RdBusy[p] = rd_busy;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Testbench for register_file_mp: BYPASS=1 and BYPASS=0 instances share stimulus
// and are checked against an array-based model of the register file.
module tb_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [4:0]       wa0, wa1, iaddr;
    logic [31:0]      wd0, wd1;
    logic             we0, we1, ivalid, flush;
    logic [1:0][4:0]  ra;
    logic [1:0][31:0] rd_b, rd_n;
    logic [1:0]       bz_b, bz_n;
    logic             rdy_b, rdy_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    logic        m_busy [32];

    register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RD_PORTS(2), .BYPASS(1)) u_byp (
        .i_Clock(clk), .i_Reset(rst_n),
        .i_WrAddr0(wa0), .i_WrData0(wd0), .i_WrEnable0(we0),
        .i_WrAddr1(wa1), .i_WrData1(wd1), .i_WrEnable1(we1),
        .i_RdAddr(ra), .o_RdData(rd_b), .o_RdBusy(bz_b),
        .i_IssueAddr(iaddr), .i_IssueValid(ivalid), .o_IssueReady(rdy_b),
        .i_Flush(flush)
    );

    register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RD_PORTS(2), .BYPASS(0)) u_nob (
        .i_Clock(clk), .i_Reset(rst_n),
        .i_WrAddr0(wa0), .i_WrData0(wd0), .i_WrEnable0(we0),
        .i_WrAddr1(wa1), .i_WrData1(wd1), .i_WrEnable1(we1),
        .i_RdAddr(ra), .o_RdData(rd_n), .o_RdBusy(bz_n),
        .i_IssueAddr(iaddr), .i_IssueValid(ivalid), .o_IssueReady(rdy_n),
        .i_Flush(flush)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (byp && we0 && wa0 == a) return wd0;
        if (byp && we1 && wa1 == a) return wd1;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return 1'b0;
        if (byp && ((we0 && wa0 == a) || (we1 && wa1 == a))) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ready();
        return rst_n && !flush && (iaddr == 5'd0 || !m_busy[iaddr]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic acc;
        if (!rst_n) return;
        acc = ivalid && exp_ready();
        if (we1 && wa1 != 5'd0) m_regs[wa1] = wd1;
        if (we0 && wa0 != 5'd0) m_regs[wa0] = wd0;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (we0 && wa0 != 5'd0) m_busy[wa0] = 1'b0;
            if (we1 && wa1 != 5'd0) m_busy[wa1] = 1'b0;
        end
        if (acc && iaddr != 5'd0) m_busy[iaddr] = 1'b1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; ivalid = 0; flush = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iaddr = 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        ra = '0;
        rst_n = 1'b0;
        model_clear();
        we0 = 1; wa0 = 5'd2; wd0 = 32'h1234_5678; ivalid = 1; iaddr = 5'd2;
        #1;
        for (int a = 0; a < 32; a++) begin
            ra[0] = 5'(a);
            ra[1] = 5'(31 - a);
            #1;
            for (int p = 0; p < 2; p++) begin
                n_cmp++; if (rd_b[p] !== 32'h0) begin n_err++; $display("FAIL reset_data_byp p%0d a%0d got %h exp 0", p, a, rd_b[p]); end
                n_cmp++; if (rd_n[p] !== 32'h0) begin n_err++; $display("FAIL reset_data_nob p%0d a%0d got %h exp 0", p, a, rd_n[p]); end
                n_cmp++; if (bz_b[p] !== 1'b0 || bz_n[p] !== 1'b0) begin n_err++; $display("FAIL reset_busy p%0d got %b/%b exp 0", p, bz_b[p], bz_n[p]); end
            end
        end
        n_cmp++; if (rdy_b !== 1'b0 || rdy_n !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b/%b exp 0", rdy_b, rdy_n); end
        tick();
        tick();
        idle();
        rst_n = 1'b1;
        ra[0] = 5'd2; ra[1] = 5'd2;
        #1;
        n_cmp++; if (rd_b[0] !== 32'h0 || rd_n[0] !== 32'h0) begin n_err++; $display("FAIL reset_ignored_write got %h/%h exp 0", rd_b[0], rd_n[0]); end
        n_cmp++; if (bz_b[0] !== 1'b0 || bz_n[0] !== 1'b0) begin n_err++; $display("FAIL reset_ignored_issue got %b/%b exp 0", bz_b[0], bz_n[0]); end
        tick();
    endtask

    task automatic test_collision();
        idle();
        we0 = 1; wa0 = 5'd1; wd0 = 32'h11;
        we1 = 1; wa1 = 5'd1; wd1 = 32'h22;
        ra[0] = 5'd1; ra[1] = 5'd1;
        #1;
        n_cmp++; if (rd_b[1] !== 32'h11) begin n_err++; $display("FAIL collision_bypass got %h exp 11", rd_b[1]); end
        tick();
        idle();
        #1;
        n_cmp++; if (rd_b[0] !== 32'h11) begin n_err++; $display("FAIL collision_byp got %h exp 11", rd_b[0]); end
        n_cmp++; if (rd_n[0] !== 32'h11) begin n_err++; $display("FAIL collision_nob got %h exp 11", rd_n[0]); end
        we0 = 1; wa0 = 5'd0; wd0 = 32'hFF;
        ra[0] = 5'd0; ra[1] = 5'd0;
        #1;
        n_cmp++; if (rd_b[0] !== 32'h0) begin n_err++; $display("FAIL x0_bypass got %h exp 0", rd_b[0]); end
        tick();
        idle();
        #1;
        n_cmp++; if (rd_b[1] !== 32'h0 || rd_n[1] !== 32'h0) begin n_err++; $display("FAIL x0_write got %h/%h exp 0", rd_b[1], rd_n[1]); end
    endtask

    task automatic test_bypass();
        idle();
        we0 = 1; wa0 = 5'd7; wd0 = 32'h0000_1234;
        tick();
        idle();
        we0 = 1; wa0 = 5'd7; wd0 = 32'hA5A5_A5A5;
        ra[0] = 5'd7; ra[1] = 5'd7;
        #1;
        for (int p = 0; p < 2; p++) begin
            n_cmp++; if (rd_b[p] !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL bypass_same p%0d got %h exp a5a5a5a5", p, rd_b[p]); end
            n_cmp++; if (rd_n[p] !== 32'h0000_1234) begin n_err++; $display("FAIL nobypass_old p%0d got %h exp 00001234", p, rd_n[p]); end
        end
        tick();
        idle();
        #1;
        n_cmp++; if (rd_n[0] !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL nobypass_next got %h exp a5a5a5a5", rd_n[0]); end
    endtask

    task automatic test_scoreboard();
        idle();
        ivalid = 1; iaddr = 5'd3;
        #1;
        n_cmp++; if (rdy_b !== 1'b1) begin n_err++; $display("FAIL issue_ready_free got %b exp 1", rdy_b); end
        tick();
        idle();
        ra[0] = 5'd3; ra[1] = 5'd3;
        #1;
        n_cmp++; if (bz_b !== 2'b11 || bz_n !== 2'b11) begin n_err++; $display("FAIL busy_set got %b/%b exp 11", bz_b, bz_n); end
        ivalid = 1; iaddr = 5'd3;
        #1;
        n_cmp++; if (rdy_b !== 1'b0 || rdy_n !== 1'b0) begin n_err++; $display("FAIL issue_ready_busy got %b/%b exp 0", rdy_b, rdy_n); end
        tick();
        idle();
        we1 = 1; wa1 = 5'd3; wd1 = 32'h33;
        #1;
        n_cmp++; if (rd_b[0] !== 32'h33 || bz_b[0] !== 1'b0) begin n_err++; $display("FAIL wb_bypass got %h/%b exp 33/0", rd_b[0], bz_b[0]); end
        n_cmp++; if (bz_n[0] !== 1'b1) begin n_err++; $display("FAIL wb_nob_busy got %b exp 1", bz_n[0]); end
        tick();
        idle();
        #1;
        n_cmp++; if (rd_n[1] !== 32'h33 || bz_n[1] !== 1'b0) begin n_err++; $display("FAIL wb_after got %h/%b exp 33/0", rd_n[1], bz_n[1]); end
    endtask

    task automatic test_issue_wb_same();
        idle();
        ivalid = 1; iaddr = 5'd4;
        we0 = 1; wa0 = 5'd4; wd0 = 32'h44;
        tick();
        idle();
        ra[0] = 5'd4; ra[1] = 5'd4;
        #1;
        n_cmp++; if (bz_b[0] !== 1'b1 || bz_n[0] !== 1'b1) begin n_err++; $display("FAIL issue_wins got %b/%b exp 1", bz_b[0], bz_n[0]); end
        n_cmp++; if (rd_b[1] !== 32'h44 || rd_n[1] !== 32'h44) begin n_err++; $display("FAIL issue_wb_data got %h/%h exp 44", rd_b[1], rd_n[1]); end
    endtask

    task automatic test_flush();
        idle();
        ivalid = 1; iaddr = 5'd8;
        tick();
        iaddr = 5'd9;
        tick();
        idle();
        flush = 1; ivalid = 1; iaddr = 5'd0;
        ra[0] = 5'd8; ra[1] = 5'd9;
        #1;
        n_cmp++; if (rdy_b !== 1'b0 || rdy_n !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b/%b exp 0", rdy_b, rdy_n); end
        n_cmp++; if (bz_b !== 2'b11) begin n_err++; $display("FAIL flush_pre_busy got %b exp 11", bz_b); end
        tick();
        idle();
        #1;
        n_cmp++; if (bz_b !== 2'b00 || bz_n !== 2'b00) begin n_err++; $display("FAIL flush_busy got %b/%b exp 00", bz_b, bz_n); end
        n_cmp++; if (rd_n[0] !== m_regs[8] || rd_n[1] !== m_regs[9]) begin n_err++; $display("FAIL flush_data got %h/%h exp %h/%h", rd_n[0], rd_n[1], m_regs[8], m_regs[9]); end
    endtask

    task automatic test_reset_midrun();
        idle();
        we0 = 1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
        tick();
        idle();
        ivalid = 1; iaddr = 5'd6;
        ra[0] = 5'd5; ra[1] = 5'd6;
        #1;
        n_cmp++; if (rd_n[0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL midrun_pre got %h exp deadbeef", rd_n[0]); end
        tick();
        idle();
        we0 = 1; wa0 = 5'd5; wd0 = 32'h0000_0001;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_cmp++; if (rd_b[0] !== 32'h0 || rd_n[0] !== 32'h0) begin n_err++; $display("FAIL midrun_async got %h/%h exp 0", rd_b[0], rd_n[0]); end
        tick();
        idle();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (rd_b[0] !== 32'h0 || rd_n[0] !== 32'h0) begin n_err++; $display("FAIL midrun_after got %h/%h exp 0", rd_b[0], rd_n[0]); end
        n_cmp++; if (bz_b[1] !== 1'b0 || bz_n[1] !== 1'b0) begin n_err++; $display("FAIL midrun_busy got %b/%b exp 0", bz_b[1], bz_n[1]); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we0    = ($urandom_range(0, 2) != 0);
            we1    = ($urandom_range(0, 2) != 0);
            wa0    = 5'($urandom_range(0, 9));
            wa1    = 5'($urandom_range(0, 9));
            wd0    = $urandom;
            wd1    = $urandom;
            ivalid = ($urandom_range(0, 1) != 0);
            iaddr  = 5'($urandom_range(0, 9));
            flush  = ($urandom_range(0, 15) == 0);
            ra[0]  = 5'($urandom_range(0, 9));
            ra[1]  = 5'($urandom_range(0, 31));
            #1;
            for (int p = 0; p < 2; p++) begin
                n_cmp++; if (rd_b[p] !== exp_data(ra[p], 1'b1)) begin n_err++; $display("FAIL rand_data_byp c%0d p%0d got %h exp %h", c, p, rd_b[p], exp_data(ra[p], 1'b1)); end
                n_cmp++; if (rd_n[p] !== exp_data(ra[p], 1'b0)) begin n_err++; $display("FAIL rand_data_nob c%0d p%0d got %h exp %h", c, p, rd_n[p], exp_data(ra[p], 1'b0)); end
                n_cmp++; if (bz_b[p] !== exp_busy(ra[p], 1'b1)) begin n_err++; $display("FAIL rand_busy_byp c%0d p%0d got %b exp %b", c, p, bz_b[p], exp_busy(ra[p], 1'b1)); end
                n_cmp++; if (bz_n[p] !== exp_busy(ra[p], 1'b0)) begin n_err++; $display("FAIL rand_busy_nob c%0d p%0d got %b exp %b", c, p, bz_n[p], exp_busy(ra[p], 1'b0)); end
            end
            n_cmp++; if (rdy_b !== exp_ready() || rdy_n !== exp_ready()) begin n_err++; $display("FAIL rand_ready c%0d got %b/%b exp %b", c, rdy_b, rdy_n, exp_ready()); end
            tick();
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        ra = '0;
        rst_n = 1'b0;
        model_clear();
        #2;
        test_reset();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_issue_wb_same();
        test_flush();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
